// File: rtl/point_profile_reader_pkg.sv
// Shared constants and state encoding for the point profile reader.
package point_pkg;
    localparam int PROFILE_LEN = 9;
    localparam int CENTER_IDX  = 4;
    localparam int STEP        = 3;
    localparam int IMG_W_DEF   = 640;
    localparam int IMG_H_DEF   = 480;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;
endpackage

// File: rtl/point_profile_reader_if.sv
// Bus bundle between the packed-point producer, the reader and the consumer.
//
// Handshake: on both the in_* and out_* sides a transfer happens on a rising
// clk edge where valid and ready are both 1. valid never depends on ready.
// While the consumer holds out_ready low, out_valid and the out_* payload
// stay stable.
interface point_profile_reader_if #(
    parameter int width = 14
);
    logic               in_valid;
    logic               in_ready;
    logic [width*4-1:0] new_xi;
    logic [width*4-1:0] new_yi;
    logic [width*4-1:0] new_xo;
    logic [width*4-1:0] new_yo;
    logic [width-1:0]   xb_o;
    logic [width-1:0]   yb_o;
    logic               out_valid;
    logic               out_ready;
    logic [width-1:0]   out_x;
    logic [width-1:0]   out_y;
    logic [3:0]         out_idx;
    logic               out_oor;
    logic               out_last;

    modport master (
        output in_valid, new_xi, new_yi, new_xo, new_yo, xb_o, yb_o, out_ready,
        input  in_ready, out_valid, out_x, out_y, out_idx, out_oor, out_last
    );

    modport slave (
        input  in_valid, new_xi, new_yi, new_xo, new_yo, xb_o, yb_o, out_ready,
        output in_ready, out_valid, out_x, out_y, out_idx, out_oor, out_last
    );
endinterface

// File: rtl/point_profile_reader_bounds_chk.sv
// Signed range check of one (x,y) point against the image rectangle.
module point_bounds_chk #(
    parameter int width = 14,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic [width-1:0] x,
    input  logic [width-1:0] y,
    output logic             oor
);
    int sx;
    int sy;

    // Coordinates are two's complement; widen with sign before comparing.
    always_comb begin
        sx  = int'($signed(x));
        sy  = int'($signed(y));
        oor = (sx < 0) || (sx >= IMG_W) || (sy < 0) || (sy >= IMG_H);
    end
endmodule

// File: rtl/point_profile_reader.sv
// Captures one packed 9-point normal profile and emits it point by point,
// innermost first, with a running count of completed profiles.
module point_profile_reader
    import point_pkg::*;
#(
    parameter int width = 14,
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    point_profile_reader_if.slave        bus,
    output logic [15:0]                  prof_cnt,
    output state_t                       state_dbg
);
    localparam logic [3:0] LAST = 4'(PROFILE_LEN - 1);

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [15:0]      prof_cnt_q;
    logic             load;
    logic             cnt_inc;
    logic             in_rdy;
    logic             emit;
    logic             oor_raw;
    logic [width-1:0] cap_x [PROFILE_LEN];
    logic [width-1:0] cap_y [PROFILE_LEN];
    logic [width-1:0] sel_x, sel_y;

    // State, position and profile counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            prof_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (cnt_inc) prof_cnt_q <= prof_cnt_q + 16'd1;
        end
    end

    // Capture register stored in emission order: inner points reversed,
    // boundary in the middle, outer points ascending.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PROFILE_LEN; i++) begin
                cap_x[i] <= '0;
                cap_y[i] <= '0;
            end
        end else if (load) begin
            for (int k = 0; k < 4; k++) begin
                cap_x[CENTER_IDX-1-k] <= bus.new_xi[width*k +: width];
                cap_y[CENTER_IDX-1-k] <= bus.new_yi[width*k +: width];
                cap_x[CENTER_IDX+1+k] <= bus.new_xo[width*k +: width];
                cap_y[CENTER_IDX+1+k] <= bus.new_yo[width*k +: width];
            end
            cap_x[CENTER_IDX] <= bus.xb_o;
            cap_y[CENTER_IDX] <= bus.yb_o;
        end
    end

    // Next state: a new profile is only accepted when idle or while the
    // final point is leaving, so captured data is never overwritten.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        in_rdy  = 1'b0;
        load    = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            IDLE: begin
                in_rdy = 1'b1;
                if (bus.in_valid) begin
                    load    = 1'b1;
                    state_d = EMIT;
                    idx_d   = '0;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (idx_q != LAST) begin
                        idx_d = idx_q + 4'd1;
                    end else begin
                        cnt_inc = 1'b1;
                        in_rdy  = 1'b1;
                        idx_d   = '0;
                        if (bus.in_valid) load = 1'b1;
                        else state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // 9:1 point select.
    always_comb begin
        sel_x = cap_x[idx_q];
        sel_y = cap_y[idx_q];
    end

    point_bounds_chk #(
        .width(width),
        .IMG_W(IMG_W),
        .IMG_H(IMG_H)
    ) u_bounds (
        .x  (sel_x),
        .y  (sel_y),
        .oor(oor_raw)
    );

    // Outputs are forced to zero during reset and while idle.
    always_comb begin
        emit          = (state_q == EMIT) && !rst;
        bus.in_ready  = in_rdy && !rst;
        bus.out_valid = emit;
        bus.out_x     = emit ? sel_x : '0;
        bus.out_y     = emit ? sel_y : '0;
        bus.out_idx   = emit ? idx_q : '0;
        bus.out_oor   = emit && oor_raw;
        bus.out_last  = emit && (idx_q == LAST);
    end

    assign prof_cnt  = prof_cnt_q;
    assign state_dbg = state_q;
endmodule
